proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Multi-cycle control FSM for the simple 8-register processor datapath (R0–R7, A, G, ALU, shared bus).
- Latches a 9-bit instruction word IIIXXXYYY from din on run, then steps a 2-bit time counter T0–T3.
- Per-step, drives the register-load enables, the bus-driver selects, the immediate select and the ALU op. Pulses done on the last step of each instruction.

Parameters:
- DATA_W, 16, width of din (instruction in din[8:0]; immediate is the full word).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- run  in  1  start fetch of the instruction on din; sampled only in T0
- din  in  DATA_W  instruction word (T0) / immediate word (mvi, T1)
- r_in  out  8  one-hot load enable for R0..R7
- r_out  out  8  one-hot bus-drive select for R0..R7
- din_out  out  1  din drives the bus (immediate select)
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- g_out  out  1  G drives the bus
- alu_op  out  2  00 add, 01 sub, 10 and, 11 pass-A
- ir_in  out  1  instruction latch strobe (T0 and run)
- count  out  2  current time step
- busy  out  1  high in T1–T3
- done  out  1  single-cycle pulse on the final step of an instruction

Behaviour:
- Reset: resetn=0 at a rising edge sets count=0 and IR=9'b0. While resetn=0, all outputs are forced to 0 combinationally, including ir_in. Reset mid-instruction aborts it: no done, count=0 the next cycle.
- Outputs are combinational from (count, IR, run). At most one of r_out/din_out/g_out is high in any cycle. All unnamed outputs are 0 in each step.
- Instruction fields are I=IR[8:6], X=IR[5:3], Y=IR[2:0].
- T0:
  - run=0: all outputs 0, count stays 0.
  - run=1: ir_in=1, IR<=din[8:0] at the edge, count->1.
- Opcodes:
  - 000 mv Rx<-Ry: T1 r_out[Y]=1, r_in[X]=1, done=1, next T0.
  - 001 mvi Rx<-#D: T1 din_out=1, r_in[X]=1, done=1, next T0. The immediate is presented on din during T1.
  - 010 add, 011 sub, 100 and (Rx<-Rx op Ry):
    - T1: r_out[X]=1, a_in=1.
    - T2: r_out[Y]=1, g_in=1, alu_op=00/01/10 respectively.
    - T3: g_out=1, r_in[X]=1, done=1, next T0.
  - 101 mvg Rx<-G: T1 g_out=1, r_in[X]=1, done=1.
  - 110, 111 reserved/NOP: T1 done=1, no enables, next T0.
- mv with X==Y is legal: r_out and r_in share the same bit. This is a no-op write.
- add/sub/and with X==Y is legal and produces Rx op Rx.
- alu_op is 00 in every step other than T2 of an ALU instruction.
- run is ignored outside T0. run held high starts a new fetch in the T0 immediately after done, giving back-to-back instructions with no idle cycle.
- IR changes only on ir_in edges, so din may change freely after T0. Only din in T1 matters, and only for mvi.
- count never reaches 2 or 3 for 1-step instructions. count wraps 3->0 only through the done step.
- done is high exactly one cycle per completed instruction. busy = (count!=0).
- Latency: mv/mvi/mvg/NOP take 2 cycles including fetch; ALU ops take 4.

Test Plan:
- Reset/idle:
  - resetn=0 for 2 cycles with run=1 -> all outputs 0, count=0.
  - Release with run=0 -> remains T0, outputs 0.
- mvi:
  - T0 din=9'b001_011_000, run=1 -> ir_in=1.
  - T1 din=16'h00A5 -> din_out=1, r_in=8'b00001000, done=1.
  - Next cycle count=0.
- add R2,R5:
  - din=9'b010_010_101 -> T1 r_out=8'h04, a_in=1.
  - T2 r_out=8'h20, g_in=1, alu_op=00.
  - T3 g_out=1, r_in=8'h04, done=1.
  - done high exactly once.
- Back-to-back:
  - run held 1; mv R1,R7 (000_001_111) then sub R1,R1 (011_001_001).
  - First done at cycle 2, second fetch in cycle 3 with no idle cycle.
  - sub T2 has alu_op=01 and r_out=8'h02.
- Reset mid-operation:
  - Assert resetn=0 during T2 of an and instruction -> next cycle count=0, no done, g_in=0.
  - IR cleared (a NOP-equivalent decode until the next fetch).
- NOP/run ignored:
  - Opcode 111 -> T1 done=1, r_in=0, r_out=0.
  - Toggling run during T1–T3 of an add does not alter the sequence or the IR.

Source files
------------

// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle control FSM for the 8-register bus datapath.
// Outputs decode combinationally from (time step, IR, run); step and IR are the only state.
module proc_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [7:0]        r_in,
    output logic [7:0]        r_out,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic [1:0]        alu_op,
    output logic              ir_in,
    output logic [1:0]        count,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3, AND = 3'd4, MVG = 3'd5;

    step_t      count_q, count_d;
    logic [8:0] ir_q, ir_d;
    logic [2:0] op;
    logic [7:0] xo, yo;
    logic       alu_i;
    logic       unused_din;

    assign unused_din = ^din[DATA_W-1:9];
    assign op    = ir_q[8:6];
    assign xo    = 8'b1 << ir_q[5:3];
    assign yo    = 8'b1 << ir_q[2:0];
    assign alu_i = (op == ADD) || (op == SUB) || (op == AND);

    always_comb begin
        r_in    = '0;
        r_out   = '0;
        din_out = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        alu_op  = 2'b00;
        ir_in   = 1'b0;
        done    = 1'b0;
        count   = 2'b00;
        busy    = 1'b0;
        if (resetn) begin
            count = count_q;
            busy  = count_q != T0;
            case (count_q)
                T0: ir_in = run;
                T1: begin
                    done    = !alu_i;
                    r_in    = (op == MV || op == MVI || op == MVG) ? xo : 8'h00;
                    r_out   = (op == MV) ? yo : alu_i ? xo : 8'h00;
                    din_out = op == MVI;
                    a_in    = alu_i;
                    g_out   = op == MVG;
                end
                T2: begin
                    r_out  = yo;
                    g_in   = 1'b1;
                    alu_op = (op == ADD) ? 2'b00 : (op == SUB) ? 2'b01 : 2'b10;
                end
                default: begin
                    g_out = 1'b1;
                    r_in  = xo;
                    done  = 1'b1;
                end
            endcase
        end
        ir_d    = ir_in ? din[8:0] : ir_q;
        // the done step always returns to T0, so 1-step instructions never see T2/T3
        count_d = (count_q == T0) ? (run ? T1 : T0) : done ? T0 : step_t'(count_q + 2'd1);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= T0;
            ir_q    <= '0;
        end else begin
            count_q <= count_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed + randomized check of proc_sequencer against an instruction-level model.
module tb_proc_sequencer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] din = '0;
    logic [7:0]  r_in, r_out;
    logic        din_out, a_in, g_in, g_out, ir_in, busy, done;
    logic [1:0]  alu_op, count;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [8:0] m_ir = '0;
    int         m_step = 0;

    proc_sequencer #(.DATA_W(16)) dut (
        .clock(clock), .resetn(resetn), .run(run), .din(din),
        .r_in(r_in), .r_out(r_out), .din_out(din_out), .a_in(a_in),
        .g_in(g_in), .g_out(g_out), .alu_op(alu_op), .ir_in(ir_in),
        .count(count), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int inst_len(input logic [2:0] op);
        return (op >= 3'd2 && op <= 3'd4) ? 3 : 1;
    endfunction

    // {r_in, r_out, din_out, a_in, g_in, g_out, alu_op, ir_in, count, busy, done}
    function automatic logic [26:0] model_out();
        logic [7:0] ri, ro, xo, yo;
        logic do_, ai, gi, go, ii, dn;
        logic [1:0] ao;
        logic [2:0] op;
        ri = 0; ro = 0; do_ = 0; ai = 0; gi = 0; go = 0; ao = 0; ii = 0; dn = 0;
        op = m_ir[8:6];
        xo = 8'd1 << m_ir[5:3];
        yo = 8'd1 << m_ir[2:0];
        if (!resetn) return '0;
        if (m_step == 0) ii = run;
        else begin
            dn = m_step == inst_len(op);
            if (m_step == 1) begin
                if (op == 3'd0) begin ro = yo; ri = xo; end
                else if (op == 3'd1) begin do_ = 1; ri = xo; end
                else if (op == 3'd5) begin go = 1; ri = xo; end
                else if (inst_len(op) == 3) begin ro = xo; ai = 1; end
            end else if (m_step == 2) begin
                ro = yo; gi = 1; ao = 2'(op - 3'd2);
            end else begin
                go = 1; ri = xo;
            end
        end
        return {ri, ro, do_, ai, gi, go, ao, ii, 2'(m_step), m_step != 0, dn};
    endfunction

    task automatic set_in(input logic rn, input logic r, input logic [15:0] d);
        @(negedge clock);
        resetn = rn; run = r; din = d;
        #1;
        chk("outputs_vs_model",
            {r_in, r_out, din_out, a_in, g_in, g_out, alu_op, ir_in, count, busy, done},
            model_out());
    endtask

    task automatic adv();
        @(posedge clock);
        if (done) done_cnt++;
        if (!resetn) begin m_step = 0; m_ir = '0; end
        else if (m_step == 0) begin
            if (run) begin m_ir = din[8:0]; m_step = 1; end
        end else m_step = (m_step == inst_len(m_ir[8:6])) ? 0 : m_step + 1;
        #1;
    endtask

    task automatic step(input logic rn, input logic r, input logic [15:0] d);
        set_in(rn, r, d);
        adv();
    endtask

    int d0;

    initial begin
        // reset held with run high
        repeat (2) begin
            set_in(0, 1, 16'h0058);
            chk("reset_all_zero", {r_in, r_out, din_out, a_in, g_in, g_out, alu_op, ir_in, count, busy, done}, 0);
            adv();
        end
        set_in(1, 0, 16'h0000);
        chk("idle_count", count, 0);
        chk("idle_ir_in", ir_in, 0);
        adv();

        // mvi R3, #A5
        set_in(1, 1, 16'h0058);
        chk("mvi_ir_in", ir_in, 1);
        adv();
        set_in(1, 0, 16'h00A5);
        chk("mvi_din_out", din_out, 1);
        chk("mvi_r_in", r_in, 8'h08);
        chk("mvi_done", done, 1);
        adv();
        set_in(1, 0, 16'h0000);
        chk("mvi_back_t0", count, 0);
        adv();

        // add R2,R5 with run toggling during execution
        d0 = done_cnt;
        step(1, 1, 16'h0095);
        set_in(1, 1, 16'h01FF);
        chk("add_t1_r_out", r_out, 8'h04);
        chk("add_t1_a_in", a_in, 1);
        adv();
        set_in(1, 0, 16'h0123);
        chk("add_t2_r_out", r_out, 8'h20);
        chk("add_t2_g_in", g_in, 1);
        chk("add_t2_alu_op", alu_op, 0);
        adv();
        set_in(1, 1, 16'h0000);
        chk("add_t3_g_out", g_out, 1);
        chk("add_t3_r_in", r_in, 8'h04);
        chk("add_t3_done", done, 1);
        adv();
        chk("add_done_once", done_cnt - d0, 1);

        // back-to-back: mv R1,R7 then sub R1,R1
        step(1, 1, 16'h000F);
        set_in(1, 1, 16'h0000);
        chk("mv_done", done, 1);
        chk("mv_r_out", r_out, 8'h80);
        adv();
        set_in(1, 1, 16'h00C9);
        chk("b2b_fetch_ir_in", ir_in, 1);
        chk("b2b_fetch_count", count, 0);
        adv();
        step(1, 1, 16'h0000);
        set_in(1, 1, 16'h0000);
        chk("sub_t2_alu_op", alu_op, 1);
        chk("sub_t2_r_out", r_out, 8'h02);
        adv();
        step(1, 0, 16'h0000);

        // reset during T2 of and R3,R4
        d0 = done_cnt;
        step(1, 1, 16'h011C);
        step(1, 0, 16'h0000);
        set_in(0, 0, 16'h0000);
        chk("rst_mid_g_in", g_in, 0);
        chk("rst_mid_done", done, 0);
        adv();
        set_in(1, 0, 16'h0000);
        chk("rst_mid_count", count, 0);
        adv();
        chk("rst_mid_no_done", done_cnt - d0, 0);

        // reserved opcode 111
        step(1, 1, 16'h01D3);
        set_in(1, 0, 16'h0000);
        chk("nop_done", done, 1);
        chk("nop_r_in", r_in, 0);
        chk("nop_r_out", r_out, 0);
        adv();

        for (int i = 0; i < 3000; i++)
            step(($urandom % 40) != 0, 1'($urandom), 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
